multicycle_control_fsm: RTL and testbench

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

---
 rtl/multicycle_control_fsm.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a retired-instruction counter.
// Optional MC_CTRL_STALL_EN adds a mem_ready input that holds MEM until the data memory is done.
module multicycle_control_fsm #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [10:0]      ins,
`ifdef MC_CTRL_STALL_EN
    input  logic             mem_ready,
`endif
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch,
    output logic             reg2loc,
    output logic             alusrc,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             memread,
    output logic             memwrite,
    output logic [1:0]       aluop,
    output logic [2:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CLS_STUR  = 2'd0,
        CLS_LDUR  = 2'd1,
        CLS_RTYPE = 2'd2,
        CLS_CBZ   = 2'd3
    } cls_t;

    state_t           state_q;
    state_t           state_d;
    cls_t             cls_q;
    cls_t             cls_d;
    cls_t             ins_cls;
    logic             mem_done;
    logic [CNT_W-1:0] count_q;
    logic             unused_ins;

    // Only three opcode bits distinguish the instruction classes handled here.
    assign unused_ins = ^{ins[10:6], ins[3:2], ins[0]};

    always_comb begin
        if (ins[5]) begin
            ins_cls = CLS_CBZ;
        end else if (ins[1]) begin
            ins_cls = CLS_LDUR;
        end else if (ins[4]) begin
            ins_cls = CLS_RTYPE;
        end else begin
            ins_cls = CLS_STUR;
        end
    end

`ifdef MC_CTRL_STALL_EN
    assign mem_done = mem_ready;
`else
    assign mem_done = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            cls_q   <= CLS_STUR;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    assign cls_d = (state_q == ST_DECODE) ? ins_cls : cls_q;

    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                case (cls_q)
                    CLS_RTYPE: state_d = ST_WB;
                    CLS_LDUR:  state_d = ST_MEM;
                    CLS_STUR:  state_d = ST_MEM;
                    default:   state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (!mem_done) begin
                    state_d = ST_MEM;
                end else if (cls_q == CLS_LDUR) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WB:     state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase
    end

    // Outputs come from state and class only, except DECODE reg2loc which must
    // look at the incoming opcode because the class register is not loaded yet.
    always_comb begin
        ir_write = 1'b0;
        pc_write = 1'b0;
        branch   = 1'b0;
        reg2loc  = 1'b0;
        alusrc   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        aluop    = 2'b00;
        retire   = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
                ST_DECODE: begin
                    reg2loc = (ins_cls != CLS_RTYPE);
                end
                ST_EXEC: begin
                    case (cls_q)
                        CLS_RTYPE: begin
                            aluop  = 2'b10;
                            alusrc = 1'b0;
                        end
                        CLS_LDUR: begin
                            aluop  = 2'b00;
                            alusrc = 1'b1;
                        end
                        CLS_STUR: begin
                            aluop   = 2'b00;
                            alusrc  = 1'b1;
                            reg2loc = 1'b1;
                        end
                        default: begin
                            aluop   = 2'b01;
                            reg2loc = 1'b1;
                            branch  = 1'b1;
                            retire  = 1'b1;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (cls_q == CLS_LDUR) begin
                        memread = 1'b1;
                    end else if (cls_q == CLS_STUR) begin
                        memwrite = 1'b1;
                        reg2loc  = 1'b1;
                        retire   = mem_done;
                    end
                end
                ST_WB: begin
                    regwrite = 1'b1;
                    memtoreg = (cls_q == CLS_LDUR);
                    retire   = 1'b1;
                end
                default: begin
                    retire = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (retire) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: per-instruction cycle plans from a reference
// model are queued and checked cycle by cycle; optional MC_CTRL_STALL_EN stall coverage.
module tb_multicycle_control_fsm;

    localparam int CNT_W = 4;
    localparam int W     = 15;
    localparam int C_STUR  = 0;
    localparam int C_LDUR  = 1;
    localparam int C_RTYPE = 2;
    localparam int C_CBZ   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [10:0]      ins;
`ifdef MC_CTRL_STALL_EN
    logic             mem_ready;
`endif
    logic             ir_write, pc_write, branch, reg2loc, alusrc;
    logic             memtoreg, regwrite, memread, memwrite, retire;
    logic [1:0]       aluop;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_count;

    int checks = 0;
    int errors = 0;
    int cnt_model = 0;
    logic [W-1:0] exp_q[$];

    multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .ins(ins),
`ifdef MC_CTRL_STALL_EN
        .mem_ready(mem_ready),
`endif
        .ir_write(ir_write),
        .pc_write(pc_write),
        .branch(branch),
        .reg2loc(reg2loc),
        .alusrc(alusrc),
        .memtoreg(memtoreg),
        .regwrite(regwrite),
        .memread(memread),
        .memwrite(memwrite),
        .aluop(aluop),
        .state(state),
        .retire(retire),
        .instr_count(instr_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int class_of(input logic [10:0] op);
        if (op[5]) return C_CBZ;
        if (op[1]) return C_LDUR;
        if (op[4]) return C_RTYPE;
        return C_STUR;
    endfunction

    function automatic logic [10:0] make_op(input int c);
        logic [10:0] r;
        r = 11'($urandom);
        case (c)
            C_CBZ:   r[5] = 1'b1;
            C_LDUR:  begin r[5] = 1'b0; r[1] = 1'b1; end
            C_RTYPE: begin r[5] = 1'b0; r[1] = 1'b0; r[4] = 1'b1; end
            default: begin r[5] = 1'b0; r[1] = 1'b0; r[4] = 1'b0; end
        endcase
        return r;
    endfunction

    // Field order: state, ir_write, pc_write, branch, reg2loc, alusrc, memtoreg,
    // regwrite, memread, memwrite, aluop, retire.
    function automatic logic [W-1:0] vec(input int st, input bit ir, input bit pc, input bit br,
                                         input bit r2l, input bit asrc, input bit m2r,
                                         input bit rw, input bit mr, input bit mw,
                                         input bit [1:0] aop, input bit ret);
        return {3'(st), ir, pc, br, r2l, asrc, m2r, rw, mr, mw, aop, ret};
    endfunction

    function automatic logic [W-1:0] observed();
        return {state, ir_write, pc_write, branch, reg2loc, alusrc, memtoreg,
                regwrite, memread, memwrite, aluop, retire};
    endfunction

    task automatic plan(input int c, input int stall);
        exp_q.push_back(vec(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
        exp_q.push_back(vec(1, 0, 0, 0, (c != C_RTYPE), 0, 0, 0, 0, 0, 2'b00, 0));
        case (c)
            C_CBZ: begin
                exp_q.push_back(vec(2, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b01, 1));
            end
            C_RTYPE: begin
                exp_q.push_back(vec(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0));
                exp_q.push_back(vec(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 1));
            end
            C_LDUR: begin
                exp_q.push_back(vec(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0));
                for (int i = 0; i <= stall; i++)
                    exp_q.push_back(vec(3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0));
                exp_q.push_back(vec(4, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 1));
            end
            default: begin
                exp_q.push_back(vec(2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 0));
                for (int i = 0; i <= stall; i++)
                    exp_q.push_back(vec(3, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2'b00, (i == stall)));
            end
        endcase
    endtask

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after the edge ending the instruction.
    task automatic run_instr(input logic [10:0] op, input int stall, input int abort_at);
        logic [W-1:0] want;
        int step;
        int mem_seen;
        step = 0;
        mem_seen = 0;
        plan(class_of(op), stall);
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            ins = (want[14:12] == 3'd1) ? op : 11'($urandom);
`ifdef MC_CTRL_STALL_EN
            if (want[14:12] == 3'd3) begin
                mem_ready = (mem_seen == stall);
                mem_seen++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
`endif
            if (step == abort_at) begin
                rst  = 1'b1;
                want = {want[14:12], 12'b0};
            end
            @(negedge clk);
            check($sformatf("cycle%0d", step), 32'(observed()), 32'(want));
            check($sformatf("count%0d", step), 32'(instr_count), 32'(cnt_model));
            @(posedge clk);
            #1;
            if (rst) begin
                rst = 1'b0;
                cnt_model = 0;
                exp_q.delete();
                break;
            end
            if (want[0]) cnt_model = (cnt_model + 1) % (1 << CNT_W);
            step++;
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int c;
        int stall;
        int abort_at;
        rst = 1'b1;
        ins = '0;
`ifdef MC_CTRL_STALL_EN
        mem_ready = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_vec", 32'(observed()), 32'(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0)));
        check("reset_count", 32'(instr_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_instr(11'b11111000010, 0, -1);
        check("ldur_count", 32'(instr_count), 32'd1);
        run_instr(11'b11111000000, 0, -1);
        run_instr(11'b10001011000, 0, -1);
        run_instr(11'b10110100000, 0, -1);
        check("four_count", 32'(instr_count), 32'd4);
        // Reset during the MEM cycle of a store.
        run_instr(11'b11111000000, 0, 3);
        check("abort_state", 32'(state), 32'd0);
        check("abort_count", 32'(instr_count), 32'd0);
`ifdef MC_CTRL_STALL_EN
        run_instr(11'b11111000010, 3, -1);
        run_instr(11'b11111000000, 2, -1);
`endif
        for (int i = 0; i < 17; i++) run_instr(make_op(C_CBZ), 0, -1);
        check("wrap_count", 32'(instr_count), 32'(cnt_model));

        for (int i = 0; i < 60; i++) begin
            c = $urandom_range(0, 3);
`ifdef MC_CTRL_STALL_EN
            stall = $urandom_range(0, 3);
`else
            stall = 0;
`endif
            abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : -1;
            run_instr(make_op(c), stall, abort_at);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
